handshake_buffer_fifo: RTL and testbench

HANDSHAKE_BUFFER_FIFO -- requirements
Module: handshake_buffer_fifo

---
 rtl/handshake_buffer_fifo_if.sv | 26 ++
 rtl/handshake_buffer_fifo.sv | 52 +++++
 tb/tb_handshake_buffer_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/handshake_buffer_fifo_if.sv
// Token handshake bundle between an upstream producer, the buffer FIFO and a downstream consumer.
// The slave modport is the FIFO side; master is the producer/consumer environment side.
interface handshake_buffer_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
);
  localparam int OCC_W = $clog2(NUM_SLOTS + 1);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid, occupancy
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid, occupancy
  );
endinterface

// File: rtl/handshake_buffer_fifo.sv
// Valid/ready token FIFO with NUM_SLOTS entries (any count 2..16), minimum latency 1, no bypass.
// Both handshake outputs derive from registered state only, so ready/valid never chain combinationally.
module handshake_buffer_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_buffer_fifo_if.slave  bus
);
  localparam int OCC_W = $clog2(NUM_SLOTS + 1);
  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(NUM_SLOTS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0] slots [NUM_SLOTS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [OCC_W-1:0]      count;
  logic                  live;
  logic                  push;
  logic                  pop;

  // live holds ins_ready low during reset and until the first edge after release.
  assign bus.ins_ready  = live && (count != FULL);
  assign bus.outs_valid = (count != '0);
  assign bus.outs       = bus.outs_valid ? slots[head] : '0;
  assign bus.occupancy  = count;

  assign push = bus.ins_valid && bus.ins_ready;
  assign pop  = bus.outs_valid && bus.outs_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live  <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      live <= 1'b1;
      if (push) tail <= (tail == LAST) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == LAST) ? '0 : head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is deliberately not reset; the outs mask hides stale entries.
  always_ff @(posedge clk) begin
    if (push) slots[tail] <= bus.ins;
  end
endmodule

// File: tb/tb_handshake_buffer_fifo.sv
// Self-checking bench: a 4-slot instance driven against a queue model, plus a 3-slot instance for the wrap stream.
module tb_handshake_buffer_fifo;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  handshake_buffer_fifo_if #(.DATA_WIDTH(DW), .NUM_SLOTS(4)) bus4 ();
  handshake_buffer_fifo_if #(.DATA_WIDTH(DW), .NUM_SLOTS(3)) bus3 ();

  handshake_buffer_fifo #(.DATA_WIDTH(DW), .NUM_SLOTS(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  handshake_buffer_fifo #(.DATA_WIDTH(DW), .NUM_SLOTS(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb4 [$];
  logic [DW-1:0] sb3 [$];
  bit m_live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, updates the model, advances one cycle.
  task automatic step4();
    logic exp_rdy, exp_vld, push, pop;
    logic [31:0] exp_out;
    exp_rdy = m_live && (sb4.size() != 4);
    exp_vld = (sb4.size() != 0);
    exp_out = exp_vld ? sb4[0] : 32'h0;
    chk("ins_ready", 32'(bus4.ins_ready), 32'(exp_rdy));
    chk("outs_valid", 32'(bus4.outs_valid), 32'(exp_vld));
    chk("outs", bus4.outs, exp_out);
    chk("occupancy", 32'(bus4.occupancy), 32'(sb4.size()));
    push = bus4.ins_valid && exp_rdy;
    pop  = exp_vld && bus4.outs_ready;
    if (pop)  void'(sb4.pop_front());
    if (push) sb4.push_back(bus4.ins);
    @(posedge clk);
    m_live = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive4(input logic v, input logic [31:0] d, input logic r);
    bus4.ins_valid  = v;
    bus4.ins        = d;
    bus4.outs_ready = r;
  endtask

  initial begin
    logic [31:0] e3;
    rst = 1'b1;
    drive4(1'b0, 32'h0, 1'b0);
    bus3.ins_valid  = 1'b0;
    bus3.ins        = '0;
    bus3.outs_ready = 1'b0;

    @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus4.ins_ready), 32'h0);
    chk("rst_valid", 32'(bus4.outs_valid), 32'h0);
    chk("rst_outs", bus4.outs, 32'h0);
    chk("rst_occ", 32'(bus4.occupancy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step4();

    // Single token
    drive4(1'b1, 32'h2B868BA3, 1'b1);
    step4();
    drive4(1'b0, 32'h0, 1'b1);
    chk("single_valid", 32'(bus4.outs_valid), 32'h1);
    chk("single_out", bus4.outs, 32'h2B868BA3);
    step4();
    chk("single_occ", 32'(bus4.occupancy), 32'h0);

    // Fill and drain with a held fifth token
    for (int v = 1; v <= 5; v++) begin
      drive4(1'b1, 32'(v), 1'b0);
      step4();
    end
    chk("full_ready", 32'(bus4.ins_ready), 32'h0);
    chk("full_occ", 32'(bus4.occupancy), 32'h4);
    drive4(1'b1, 32'h5, 1'b1);
    step4();
    step4();
    drive4(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step4();
    chk("drain_occ", 32'(bus4.occupancy), 32'h0);

    // Full with simultaneous pop: push refused, then accepted next cycle
    for (int v = 0; v < 4; v++) begin
      drive4(1'b1, 32'h100 + 32'(v), 1'b0);
      step4();
    end
    drive4(1'b1, 32'hA5A5_0001, 1'b1);
    step4();
    chk("fwp_occ_after_pop", 32'(bus4.occupancy), 32'h3);
    drive4(1'b1, 32'hA5A5_0001, 1'b0);
    step4();
    chk("fwp_occ_refill", 32'(bus4.occupancy), 32'h4);
    drive4(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step4();

    // Streaming wrap through the 3-slot instance
    for (int c = 0; c <= 10; c++) begin
      bus3.ins_valid  = (c < 10);
      bus3.ins        = 32'(c);
      bus3.outs_ready = 1'b1;
      chk("s3_ready", 32'(bus3.ins_ready), 32'h1);
      chk("s3_valid", 32'(bus3.outs_valid), 32'(c > 0));
      if (bus3.outs_valid && bus3.outs_ready) begin
        if (sb3.size() != 0) e3 = sb3.pop_front();
        else e3 = 32'hFFFF_FFFF;
        chk("s3_data", bus3.outs, e3);
      end
      if (bus3.ins_valid) sb3.push_back(bus3.ins);
      @(posedge clk);
      @(negedge clk);
    end
    bus3.ins_valid  = 1'b0;
    bus3.outs_ready = 1'b0;
    chk("s3_occ", 32'(bus3.occupancy), 32'h0);
    chk("s3_left", 32'(sb3.size()), 32'h0);

    // Random backpressure, ins wanders even when not valid
    for (int i = 0; i < 1000; i++) begin
      drive4(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      step4();
    end
    drive4(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step4();
    chk("rand_left", 32'(sb4.size()), 32'h0);

    // Mid-operation asynchronous reset during a handshake cycle
    drive4(1'b1, 32'h11, 1'b0);
    step4();
    drive4(1'b1, 32'h22, 1'b0);
    step4();
    chk("mid_occ2", 32'(bus4.occupancy), 32'h2);
    drive4(1'b1, 32'h33, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(bus4.outs_valid), 32'h0);
    chk("mid_outs", bus4.outs, 32'h0);
    chk("mid_occ", 32'(bus4.occupancy), 32'h0);
    chk("mid_ready", 32'(bus4.ins_ready), 32'h0);
    @(negedge clk);
    chk("mid_hold_occ", 32'(bus4.occupancy), 32'h0);
    rst = 1'b0;
    sb4.delete();
    m_live = 1'b0;
    drive4(1'b0, 32'h0, 1'b0);
    step4();
    drive4(1'b1, 32'h77, 1'b0);
    step4();
    chk("post_first", bus4.outs, 32'h77);
    drive4(1'b1, 32'h88, 1'b1);
    step4();
    drive4(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step4();
    chk("post_left", 32'(sb4.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
